// File: rtl/seq_counter_pkg.sv
// ---------------------------------------------------------------------------
// seq_counter_pkg
//   Shared types and constants for the sequence pattern counter.
//   - NIBBLE_W / TABLE_DEPTH : nibble width and number of table entries
//   - nibble_t               : one table entry / displayed digit
//   - table_t                : the full 16-entry pattern table
//   - DEFAULT_TABLE          : reset pattern, T[i] = (3*i) mod 16
// ---------------------------------------------------------------------------
package seq_counter_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int TABLE_DEPTH = 16;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef nibble_t table_t [TABLE_DEPTH];

  // 3 is odd, so (3*i) mod 16 visits every nibble exactly once.
  localparam table_t DEFAULT_TABLE = '{
    4'h0, 4'h3, 4'h6, 4'h9, 4'hC, 4'hF, 4'h2, 4'h5,
    4'h8, 4'hB, 4'hE, 4'h1, 4'h4, 4'h7, 4'hA, 4'hD
  };

endpackage

// File: rtl/step_prescaler.sv
// ---------------------------------------------------------------------------
// step_prescaler
//   Divides clk down to a one-cycle step tick every CLK_DIV enabled cycles.
//   Ports:
//     clk   in  system clock
//     reset in  asynchronous, active-high; clears the count
//     en    in  1 = count, 0 = freeze (partial period is kept)
//     tick  out high for the one cycle where the count sits at CLK_DIV-1
//               while enabled; the consumer acts on the following edge
//   Parameters: CLK_DIV (>= 2), DIV_W with 2**DIV_W >= CLK_DIV.
// ---------------------------------------------------------------------------
module step_prescaler #(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count;

  assign tick = en && (count == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (count == TERM) count <= '0;
      else               count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_counter.sv
// ---------------------------------------------------------------------------
// seq_pattern_counter
//   Steps through a programmable 16x4 nibble table at a prescaled rate and
//   presents the current entry to the 7-segment decoder.
//   Ports:
//     clk      in  system clock
//     reset    in  asynchronous, active-high; restores the default table
//     run      in  1 = advance on prescaler ticks, 0 = hold
//     dir      in  0 = forward, 1 = backward (sampled on ticks only)
//     last     in  index of the final active entry (sampled on ticks only)
//     wr_en    in  table write strobe
//     wr_addr  in  entry to write
//     wr_data  in  nibble to store
//     step_btn in  (SEQ_MANUAL_STEP_EN only) async pushbutton, one tick per
//                  press while run=0
//     value    out current table nibble, registered
//     index    out current table index, registered
//     step     out one-cycle pulse when index/value move on a tick
//     wrap     out one-cycle pulse with step when the index wraps
//   Build option: define SEQ_MANUAL_STEP_EN to add the manual step button.
// ---------------------------------------------------------------------------
module seq_pattern_counter
  import seq_counter_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       dir,
  input  logic [3:0] last,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
`ifdef SEQ_MANUAL_STEP_EN
  input  logic       step_btn,
`endif
  output logic [3:0] value,
  output logic [3:0] index,
  output logic       step,
  output logic       wrap
);

  table_t  tbl;
  logic    presc_tick;
  logic    tick;
  nibble_t next_idx;
  logic    next_wrap;

  step_prescaler #(
    .CLK_DIV(CLK_DIV),
    .DIV_W  (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (run),
    .tick (presc_tick)
  );

`ifdef SEQ_MANUAL_STEP_EN
  // Two flops resynchronise the button; the third holds the previous
  // synchronised level for rising-edge detection.
  logic btn_s1, btn_s2, btn_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_s1   <= step_btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign tick = presc_tick | (~run & btn_s2 & ~btn_prev);
`else
  assign tick = presc_tick;
`endif

  // Next index. Forward uses >= so that lowering `last` below the current
  // index wraps to 0 on the next tick instead of running past it.
  always_comb begin
    next_idx  = index;
    next_wrap = 1'b0;
    if (!dir) begin
      if (index >= last) begin
        next_idx  = '0;
        next_wrap = 1'b1;
      end else begin
        next_idx = index + 4'd1;
      end
    end else begin
      if (index == '0) begin
        next_idx  = last;
        next_wrap = 1'b1;
      end else begin
        next_idx = index - 4'd1;
      end
    end
  end

  // Table and output registers. A write in the same cycle as a tick is
  // forwarded to `value` when it targets the entry being stepped to; a write
  // to the displayed entry without a tick is forwarded directly, so `value`
  // always equals tbl[index].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl   <= DEFAULT_TABLE;
      index <= '0;
      value <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      if (wr_en) tbl[wr_addr] <= wr_data;

      if (tick) begin
        index <= next_idx;
        value <= (wr_en && (wr_addr == next_idx)) ? wr_data : tbl[next_idx];
        step  <= 1'b1;
        wrap  <= next_wrap;
      end else begin
        step <= 1'b0;
        wrap <= 1'b0;
        if (wr_en && (wr_addr == index)) value <= wr_data;
      end
    end
  end

endmodule

// File: doc/seq_pattern_counter.md
Name: seq_pattern_counter

Overview:
- Upstream feeder for the 7-segment hex decoder: produces the 4-bit `value` nibble that the decoder renders.
- Steps through a programmable, non-sequential sequence of up to 16 nibbles held in an internal 16x4 register table.
- Steps at a prescaled rate, forward or backward, with run/hold control and a runtime table write port.

Parameters:
- CLK_DIV, 50000000, clock cycles per sequence step (minimum 2).
- DIV_W, 26, prescaler width; must satisfy 2**DIV_W >= CLK_DIV.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  1 = prescaler counts and sequence advances; 0 = hold.
- dir  input  1  0 = forward (index up), 1 = backward (index down).
- last  input  4  index of final active table entry (sequence length = last+1).
- wr_en  input  1  table write strobe, one entry per cycle.
- wr_addr  input  4  table entry to write.
- wr_data  input  4  nibble to store.
- value  output  4  current sequence nibble, registered, drives decoder.
- index  output  4  current table index, registered.
- step  output  1  one-cycle pulse on the cycle `index`/`value` change due to a tick.
- wrap  output  1  one-cycle pulse, coincident with `step`, when index wraps.

Behaviour:
- Reset (async, active-high, immediate):
  - table = default pattern T[i] = (3*i) mod 16, i.e. 0,3,6,9,C,F,2,5,8,B,E,1,4,7,A,D.
  - index=0, value=0, step=0, wrap=0, prescaler=0.
- Prescaler, while run=1:
  - counts 0..CLK_DIV-1; a tick is asserted internally when the count equals CLK_DIV-1, and the count returns to 0.
  - run=0 freezes the count; it is not cleared, so resuming continues the partial period.
- On a tick, the next index is computed as follows:
  - forward: index >= last -> 0 with wrap=1; else index+1.
  - backward: index == 0 -> last with wrap=1; else index-1.
  - `last` lowered below the current index: the next forward tick goes to 0 (wrap). Backward ticks decrement normally.
- Step update:
  - index, value=T[next], step=1 and wrap are all registered on the tick edge.
  - Latency: the outputs change on the clock edge after the prescaler reaches its terminal count.
- Table write:
  - wr_en=1 writes T[wr_addr]=wr_data at the clock edge.
  - If wr_addr equals the current index and no tick occurs that cycle, `value` updates to wr_data on the same edge (value tracks the table with no stale display).
- Simultaneous write and tick:
  - The write commits first.
  - If wr_addr equals the next index, `value` takes wr_data.
  - Writes to any other address do not disturb the step.
- last=0: the sequence holds at index 0, and wrap pulses on every tick.
- `dir` and `last` are sampled only on tick cycles; changes between ticks have no effect until the next tick.
- Reset asserted mid-period or mid-write: everything returns to its reset values, including the table; the in-flight write is lost.

Optional Feature:
- Macro: SEQ_MANUAL_STEP_EN.
- When defined:
  - Adds input port `step_btn` (1 bit, asynchronous pushbutton).
  - step_btn passes through a 2-flop synchronizer plus rising-edge detect.
  - While run=0, each detected rising edge acts as exactly one tick (same dir/last/wrap rules, step pulses).
  - While run=1 the button is ignored.
  - The synchronizer flops reset to 0.
- When not defined: the port is absent, and the sequence advances only via the prescaler.

Decomposition:
- Package seq_counter_pkg:
  - NIBBLE_W=4 and TABLE_DEPTH=16 constants.
  - nibble_t typedef.
  - DEFAULT_TABLE constant array (the reset pattern above).
- One sub-module, step_prescaler: parameter CLK_DIV, inputs clk/reset/en, output tick pulse.
- The table, index logic and outputs stay in the top module.

Test Plan (CLK_DIV=4 in bench):
- Reset release, run=1, dir=0, last=15 -> value steps 0,3,6,9,C,F,2,... every 4 clocks; step pulses each change; wrap pulses on the return to 0 after D.
- dir=1 from index 0, last=5 -> index goes 5,4,3,2,1,0,5; value F,C,9,6,3,0,F; wrap pulses on the 0->5 transition.
- run=0 after 2 prescaler counts, hold 10 clocks, run=1 -> the next step occurs exactly 2 clocks after resume; no step pulses while held.
- Write wr_addr=current index, wr_data=7, no tick -> value=7 on the next edge. Write colliding with a tick to the next index, wr_data=A -> value=A with step=1.
- At index 9, set last=4, forward tick -> index=0, value=0, wrap=1. Set last=0 -> value stays 0 and wrap pulses every tick.
- Assert reset mid-period after rewriting T[1]=E -> all outputs 0; after release the first step shows value=3 (table restored).
